// File: rtl/fifo_nibble_packer.sv
// Paced drain of the nibble FIFO: pops one entry per PACE clocks (at most one in flight),
// packs PACK entries per word (lane 0 oldest), and offers each word on a valid/ready port.
module fifo_nibble_packer #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned PACK   = 4,
  parameter int unsigned PACE   = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic [DATA_W-1:0]        fifo_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W*PACK-1:0]   out_data,
  output logic [CNT_W-1:0]         pop_count
);

  localparam int unsigned WORD_W = DATA_W * PACK;
  localparam int unsigned IDX_W  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned PACE_W = (PACE > 1) ? $clog2(PACE) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PACK - 1);
  localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'(PACE - 1);

  logic [PACE_W-1:0] pace_cnt;
  logic [IDX_W-1:0]  pack_idx;
  logic              inflight;
  logic [WORD_W-1:0] assembly;
  logic [WORD_W-1:0] assembly_next;
  logic              last_lane;
  logic              word_done;
  logic              word_taken;

  assign last_lane  = (pack_idx == LAST_IDX);
  assign word_done  = inflight && last_lane;
  assign word_taken = out_valid && out_ready;

  // Reads stall once the last lane would complete a word the output cannot take yet.
  always_comb begin
    fifo_rd_en = !rst && !inflight && (pace_cnt == '0) && !fifo_empty
                 && !(out_valid && last_lane);
  end

  always_comb begin
    assembly_next = assembly;
    if (inflight) begin
      for (int i = 0; i < int'(PACK); i++) begin
        if (pack_idx == IDX_W'(i)) assembly_next[i*DATA_W +: DATA_W] = fifo_rd_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pace_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (fifo_rd_en)
        pace_cnt <= PACE_LOAD;
      else if (pace_cnt != '0)
        pace_cnt <= pace_cnt - PACE_W'(1);
    end
  end

  // Capture the entry popped last cycle into its lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      assembly  <= '0;
      pack_idx  <= '0;
      pop_count <= '0;
    end else if (inflight) begin
      assembly <= assembly_next;
      if (pop_count != '1) pop_count <= pop_count + CNT_W'(1);
      if (last_lane)
        pack_idx <= '0;
      else
        pack_idx <= pack_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (word_done) begin
      out_valid <= 1'b1;
      out_data  <= assembly_next;
    end else if (word_taken) begin
      out_valid <= 1'b0;
    end
  end

endmodule
